// File: rtl/div_pkg.sv
// Shared types and sizing for the 4-bit restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int DIV_W = 4;
  localparam int CNT_W = $clog2(DIV_W);
endpackage

// File: rtl/restoring_div_4_if.sv
// Request/result bundle between a controller (master) and the divider (slave).
interface restoring_div_4_if;
  import div_pkg::*;
  // start is a single-cycle request; it is taken only when busy=0 (IDLE or DONE),
  // and operands are captured on that same edge. done pulses for one cycle with
  // results valid; quotient/remainder/div_by_zero hold until the next taken start.
  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/subtr_4.sv
// 4-bit subtractor: d = a - b, bo = borrow-out (a < b).
module subtr_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] d,
  output logic       bo
);
  assign {bo, d} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/restoring_div_4.sv
// Sequential unsigned restoring divider, one quotient bit per clock through a shared subtractor.
module restoring_div_4
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  restoring_div_4_if.slave dv,
  output div_state_t state_o
);

  if (WIDTH != DIV_W) begin : g_width_check
    $error("restoring_div_4: WIDTH must be 4");
  end

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] p_q, p_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] divisor_q;
  logic [DIV_W-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q, dz_q;

  logic [DIV_W-1:0] s_w, d_w;
  logic             bo_w, acc_w;

  // Shift in the next dividend bit; a carried-out MSB guarantees the subtract succeeds.
  assign s_w = {p_q[DIV_W-2:0], q_q[DIV_W-1]};

  subtr_4 u_sub (
    .a  (s_w),
    .b  (divisor_q),
    .d  (d_w),
    .bo (bo_w)
  );

  always_comb begin
    acc_w = p_q[DIV_W-1] | ~bo_w;
    p_d   = acc_w ? d_w : s_w;
    q_d   = {q_q[DIV_W-2:0], acc_w};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (dv.start) begin
            if (dv.divisor != '0) begin
              state_q   <= RUN;
              q_q       <= dv.dividend;
              p_q       <= '0;
              cnt_q     <= CNT_W'(DIV_W - 1);
              divisor_q <= dv.divisor;
              busy_q    <= 1'b1;
              dz_q      <= 1'b0;
            end else begin
              state_q     <= DONE;
              quotient_q  <= '1;
              remainder_q <= dv.dividend;
              dz_q        <= 1'b1;
              done_q      <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          p_q <= p_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= p_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dv.busy        = busy_q;
  assign dv.done        = done_q;
  assign dv.quotient    = quotient_q;
  assign dv.remainder   = remainder_q;
  assign dv.div_by_zero = dz_q;
  assign state_o        = state_q;

endmodule
